// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Multiplexed 7-segment display driver. A binary value is captured over a
// load/busy handshake, converted to BCD by a sequential double-dabble
// converter (one bit per cycle), and the result is scanned onto a
// common-digit display of DIGITS positions, MSD first, each digit held for
// DWELL cycles. Values that do not fit in DIGITS decimal digits raise ovf
// and every digit shows a dash.
//
// Optional feature (macro SEG_LZB_EN):
//   defined   - leading-zero blanking; the LSD is never blanked and
//               blanking is suppressed while ovf=1.
//   undefined - every digit is shown, leading zeros render as "0".
//
// Parameters:
//   WIDTH  - bit width of the binary input value (2..20)
//   DIGITS - number of display digits (1..8)
//   DWELL  - clock cycles each digit is driven before advancing (>=1)
//
// Ports:
//   clk_16k - system clock, all logic on its rising edge
//   rst     - synchronous active-high reset
//   value   - unsigned binary value to display
//   load    - capture request, honoured only while busy=0
//   busy    - conversion in progress
//   ovf     - last converted value >= 10^DIGITS
//   OL      - segment pattern {a,b,c,d,e,f,g}, OL[6]=a, active-high
//   DIG     - one-hot digit strobe, DIG[DIGITS-1] is the MSD
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4,
  parameter int DWELL  = 4
) (
  input  logic              clk_16k,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        OL,
  output logic [DIGITS-1:0] DIG
);

  // Number of decimal digits needed for the largest WIDTH-bit value.
  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  // Scratch register holds every WIDTH-bit value plus one spare digit, and
  // is never narrower than the display so the low DIGITS nibbles exist.
  localparam int BCD_N = (dec_digits(WIDTH) + 1 > DIGITS) ? dec_digits(WIDTH) + 1 : DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0]     CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [PW-1:0]     PTR_MSD    = PW'(DIGITS - 1);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DIGITS-1:0] DIG_ONE    = DIGITS'(1);

  // One double-dabble step: correct every nibble >= 5, then shift in a bit.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b,
                                              input logic            in_bit);
    logic [BCD_W-1:0] t;
    t = b;
    for (int i = 0; i < BCD_N; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[BCD_W-2:0], in_bit};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  state_t                state_nx;
  logic                  start;
  logic                  done;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      bin_sh;
  logic [BCD_W-1:0]      bcd_sh;
  logic [BCD_W-1:0]      bcd_nx;
  logic                  ovf_nx;
  logic [4*DIGITS-1:0]   disp;
  logic [PW-1:0]         ptr;
  logic [DW-1:0]         dwell;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            cur_nib;
  logic [6:0]            ol_nx;

  // ---- converter control ----
  always_ff @(posedge clk_16k) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start    = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // busy is exactly the SHIFT state, so a load on the completion edge is
  // still seen with busy=1 and dropped.
  assign busy = (state == SHIFT);

  always_ff @(posedge clk_16k) begin
    if (rst)                         cnt <= '0;
    else if (start)                  cnt <= CNT_LAST;
    else if (state == SHIFT)         cnt <= cnt - 1'b1;
  end

  // ---- converter datapath ----
  assign bcd_nx = dabble(bcd_sh, bin_sh[WIDTH-1]);

  always_ff @(posedge clk_16k) begin
    if (start) begin
      bin_sh <= value;
      bcd_sh <= '0;
    end else if (state == SHIFT) begin
      bin_sh <= bin_sh << 1;
      bcd_sh <= bcd_nx;
    end
  end

  // Any non-zero nibble beyond the displayed ones means the value overflows.
  always_comb begin
    ovf_nx = 1'b0;
    for (int i = DIGITS; i < BCD_N; i++) begin
      if (bcd_nx[4*i +: 4] != 4'd0) ovf_nx = 1'b1;
    end
  end

  // ---- displayed register: updated only at conversion completion ----
  always_ff @(posedge clk_16k) begin
    if (rst) begin
      disp <= '0;
      ovf  <= 1'b0;
    end else if (done) begin
      disp <= bcd_nx[4*DIGITS-1:0];
      ovf  <= ovf_nx;
    end
  end

  // ---- leading-zero blanking mask ----
  always_comb begin
    blank = '0;
`ifdef SEG_LZB_EN
    begin : lzb
      logic zero_run;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_run = zero_run & (disp[4*i +: 4] == 4'd0);
        blank[i] = zero_run;
      end
    end
`endif
  end

  // ---- segment selection for the digit under the pointer ----
  always_comb begin
    cur_nib = disp[4*ptr +: 4];
    ol_nx   = seg7(cur_nib);
    if (ovf)             ol_nx = 7'b0000001;
    else if (blank[ptr]) ol_nx = 7'b0000000;
  end

  // ---- scanner: OL and DIG registered together ----
  always_ff @(posedge clk_16k) begin
    if (rst) begin
      ptr   <= PTR_MSD;
      dwell <= '0;
      DIG   <= '0;
      OL    <= '0;
    end else begin
      DIG <= DIG_ONE << ptr;
      OL  <= ol_nx;
      if (dwell == DWELL_LAST) begin
        dwell <= '0;
        ptr   <= (ptr == '0) ? PTR_MSD : ptr - 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule
